irq_dispatch: RTL
=================

Name: irq_dispatch

Overview:
- Consumer of the control-register file's `interrupt_state`: picks the highest-priority pending, enabled interrupt and raises a trap request to the pipeline.
- Supplies the handler vector and exception flags (efg) that travel down the pipe.
- Tracks the interrupt through writeback (taken) and return (`rfi`), then re-arms.
- Sits between the control-register file and the fetch/exception-injection logic.

Parameters:
- NUM_IRQ, 16, number of interrupt lines examined (bits [NUM_IRQ-1:0] of interrupt_state); legal 1..16.
- VECTOR_BASE, 32'h0000_0100, byte address of the handler vector table.
- REARM_CYCLES, 2, idle cycles after rfi before a new request may be raised; legal 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- interrupt_state  input  32  pending&enabled mask from the control-register file; all-zero when globally disabled.
- stall  input  1  pipeline stall; when high all internal state holds.
- irq_taken  input  1  pulse: interrupt trap reached writeback (exc_in_wb & interrupt_in_wb).
- rfi_in_wb  input  1  pulse: return-from-interrupt reached writeback.
- irq_req  output  1  trap request to the pipeline.
- irq_num  output  4  index of the requested/serviced interrupt.
- irq_vector  output  32  VECTOR_BASE + (irq_num << 2).
- irq_efg  output  32  bit 31 = 1 (interrupt cause), bits[15:0] = one-hot(irq_num), other bits 0.
- busy  output  1  high in REQ or SERVICE.

Behaviour:
- Reset (rst=1 at edge, overrides stall): state IDLE; irq_req=0, irq_num=0, busy=0, rearm counter=0.
  - irq_vector = VECTOR_BASE and irq_efg = 32'h8000_0001 while irq_num=0.
- All outputs are registered (irq_vector/irq_efg derived combinationally from the registered irq_num).
- When stall=1, nothing changes and irq_taken/rfi_in_wb are ignored; they are sampled only on cycles with stall=0.
- Priority: lowest set index in interrupt_state[NUM_IRQ-1:0] wins. Bits [31:NUM_IRQ] are ignored.
- State IDLE:
  - If the masked interrupt_state is nonzero: latch the winner into irq_num, go to REQ.
  - irq_req=1 from the next cycle, i.e. 1-cycle latency from mask to request.
- State REQ:
  - irq_req=1, busy=1; irq_num is frozen, even if a higher-priority bit appears.
  - irq_taken → SERVICE, irq_req=0 next cycle.
  - Else if the latched bit interrupt_state[irq_num] is 0 (software cleared or disabled) → withdraw to IDLE, irq_req=0 next cycle.
  - irq_taken and a cleared bit in the same cycle: irq_taken wins → SERVICE.
- State SERVICE:
  - irq_req=0, busy=1, irq_num held.
  - New pending bits are ignored; the pipeline has cleared the global enable.
  - rfi_in_wb → REARM; load counter with REARM_CYCLES-1.
- State REARM:
  - busy=0, irq_req=0.
  - Counter decrements each unstalled cycle; at 0 → IDLE.
  - This covers the control-register re-enable write landing after rfi.
- irq_taken in IDLE or REARM: ignored, no state change.
- rfi_in_wb outside SERVICE: ignored.
- Reset asserted mid-request or mid-service: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: IRQ_STATS_EN.
- When defined, adds outputs irq_count (32) and irq_max_latency (16), both reset to 0.
  - irq_count increments on each accepted irq_taken and wraps at 2^32.
  - A latency counter clears on entry to REQ and increments each REQ cycle, stalled cycles included.
  - On irq_taken, irq_max_latency = max(irq_max_latency, latency+1), saturating at 16'hFFFF.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: rst=1 two cycles, then interrupt_state=0 for 5 cycles → irq_req=0, busy=0, irq_vector=32'h100, irq_efg=32'h8000_0001 throughout.
- Priority: interrupt_state=32'h8000_0028 →
  - next cycle irq_req=1, irq_num=3, irq_vector=32'h10C, irq_efg=32'h8000_0008.
  - Change state to 32'h8000_0022: irq_num stays 3? No, bit 3 cleared → irq_req drops next cycle, then re-request with irq_num=1.
- Take/return: request num 5, pulse irq_taken → irq_req=0, busy=1.
  - Hold interrupt_state=32'h8000_0001: no request.
  - Pulse rfi_in_wb → busy=0; irq_req rises exactly REARM_CYCLES+1=3 cycles after the rfi edge with irq_num=0.
- Stall: in REQ, assert stall 4 cycles while pulsing irq_taken → ignored, irq_req stays 1.
  - Deassert stall, pulse irq_taken → SERVICE.
- Simultaneous: in REQ (num 2), irq_taken=1 on the same cycle interrupt_state[2] drops → SERVICE, not IDLE; busy=1.
- With IRQ_STATS_EN: three interrupts taken after 1, 4, 2 REQ cycles → irq_count=3, irq_max_latency=4; rst mid-SERVICE → both 0, busy=0.

Source files
------------

// File: rtl/irq_dispatch.sv
// irq_dispatch
//   Picks the highest-priority (lowest index) pending, enabled interrupt from
//   the control-register file's interrupt_state. It raises a trap request to
//   the pipeline and follows that interrupt through writeback (irq_taken) and
//   return (rfi_in_wb). After a short re-arm window it accepts a new request.
//
//   Optional build macro: IRQ_STATS_EN adds irq_count / irq_max_latency.
//
// Ports
//   clk              clock, all state on rising edge
//   rst              synchronous active-high reset (overrides stall)
//   interrupt_state  pending & enabled mask, bits [NUM_IRQ-1:0] examined
//   stall            pipeline stall, all state holds while high
//   irq_taken        pulse, interrupt trap reached writeback
//   rfi_in_wb        pulse, return-from-interrupt reached writeback
//   irq_req          registered trap request
//   irq_num          index of requested / serviced interrupt
//   irq_vector       VECTOR_BASE + irq_num*4
//   irq_efg          {1'b1 cause bit, ..., one-hot(irq_num) in [15:0]}
//   busy             high while requesting or servicing
//   irq_count        (IRQ_STATS_EN) accepted interrupts, wraps
//   irq_max_latency  (IRQ_STATS_EN) worst request-to-take latency, saturating
//
// Handshake: irq_req stays high until the pipeline answers with irq_taken on
// an unstalled cycle, or until software clears the latched pending bit. In
// that case the request is withdrawn. The index is frozen while requesting.
module irq_dispatch #(
    parameter int          NUM_IRQ      = 16,
    parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
    parameter int          REARM_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] interrupt_state,
    input  logic        stall,
    input  logic        irq_taken,
    input  logic        rfi_in_wb,
    output logic        irq_req,
    output logic [3:0]  irq_num,
    output logic [31:0] irq_vector,
    output logic [31:0] irq_efg,
`ifdef IRQ_STATS_EN
    output logic [31:0] irq_count,
    output logic [15:0] irq_max_latency,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_REARM   = 2'd3
    } state_t;

    // State is kept as a named signal so checkers can bind to it.
    state_t     state_q, state_d;
    logic [3:0] num_q, num_d;
    logic [3:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;

    logic       win_valid;
    logic [3:0] win_num;
    logic       latched_bit;

    // Lowest set index wins. Scan from the top so the lowest index is the
    // last one written.
    always_comb begin
        win_valid = 1'b0;
        win_num   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (interrupt_state[i]) begin
                win_valid = 1'b1;
                win_num   = 4'(i);
            end
        end
    end

    // num_q is only ever loaded from win_num, so it always stays below NUM_IRQ.
    assign latched_bit = interrupt_state[num_q];

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_REQ;
                    num_d   = win_num;
                end
            end
            ST_REQ: begin
                // A take in the same cycle as a clear still counts as a take.
                if (irq_taken) begin
                    state_d = ST_SERVICE;
                end else if (!latched_bit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (rfi_in_wb) begin
                    state_d = ST_REARM;
                    cnt_d   = 4'(REARM_CYCLES - 1);
                end
            end
            ST_REARM: begin
                // This window lets the control-register re-enable write land.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_REQ) || (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= 4'd0;
            cnt_q   <= 4'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    assign irq_req    = req_q;
    assign busy       = busy_q;
    assign irq_num    = num_q;
    assign irq_vector = VECTOR_BASE + {26'd0, num_q, 2'b00};
    assign irq_efg    = 32'h8000_0000 | (32'h0000_0001 << num_q);

`ifdef IRQ_STATS_EN
    logic [15:0] lat_q;
    logic [15:0] lat_inc;
    logic [31:0] count_q;
    logic [15:0] max_q;
    logic        accept;

    assign lat_inc = (lat_q == 16'hFFFF) ? 16'hFFFF : lat_q + 16'd1;
    assign accept  = !stall && (state_q == ST_REQ) && irq_taken;

    // The latency counter runs through stalls, so it measures the wall-clock
    // time the request waited.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q   <= 16'd0;
            count_q <= 32'd0;
            max_q   <= 16'd0;
        end else begin
            if (!stall && (state_q == ST_IDLE) && (state_d == ST_REQ)) begin
                lat_q <= 16'd0;
            end else if (state_q == ST_REQ) begin
                lat_q <= lat_inc;
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
                if (lat_inc > max_q) begin
                    max_q <= lat_inc;
                end
            end
        end
    end

    assign irq_count       = count_q;
    assign irq_max_latency = max_q;
`endif

endmodule
